data_mem_io: RTL and testbench

Data-side memory and I/O slave for the RISC-V core. It terminates the core's data port (address, write data, read/write strobe, access size) with a word-organised RAM that supports byte, halfword and word accesses. It also provides a memory-mapped I/O window that drives the 16-bit `DOUT` pins, samples the 16-bit `DIN` pins and holds a 32-bit compare timer. It sits directly downstream of the core's load/store path; its `DIN`/`DOUT` pins are the system-level pins that the testbench drives and checks.

---
 rtl/data_mem_pkg.sv | 28 ++
 rtl/io_timer.sv | 46 ++++
 rtl/data_mem_io.sv | 95 +++++++++
 tb/tb_data_mem_io.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types, I/O register map and reset constants for data_mem_io.
package data_mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } dsize_t;

    localparam logic [4:0] OFF_DOUT  = 5'h00;
    localparam logic [4:0] OFF_DIN   = 5'h04;
    localparam logic [4:0] OFF_TIMER = 5'h08;
    localparam logic [4:0] OFF_TCMP  = 5'h0C;
    localparam logic [4:0] OFF_TCTRL = 5'h10;
    localparam logic [4:0] OFF_TSTAT = 5'h14;

    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_AR    = 1;
    localparam int TSTAT_MATCH = 0;

    localparam logic [31:0] TIMER_RST = 32'h0000_0000;
    localparam logic [31:0] TCMP_RST  = 32'hFFFF_FFFF;
    localparam logic [1:0]  TCTRL_RST = 2'b00;
    localparam logic [15:0] DOUT_RST  = 16'h0000;

endpackage

// File: rtl/io_timer.sv
// io_timer: compare timer with auto-reload and a W1C match flag.
module io_timer
    import data_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] timer,
    output logic [31:0] tcmp,
    output logic [1:0]  tctrl,
    output logic        flag
);
    logic        wr_timer, wr_tcmp, wr_tctrl, wr_tstat, active, match, flag_d;
    logic [31:0] timer_d;

    always_comb begin
        wr_timer = we && off == OFF_TIMER;
        wr_tcmp  = we && off == OFF_TCMP;
        wr_tctrl = we && off == OFF_TCTRL;
        wr_tstat = we && off == OFF_TSTAT;
        // a disabling write freezes the count and suppresses the match on the same edge
        active   = tctrl[TCTRL_EN] && !(wr_tctrl && !wdata[TCTRL_EN]);
        match    = active && timer == tcmp;
        timer_d  = wr_timer ? wdata :
                   (match && tctrl[TCTRL_AR]) ? 32'h0 :
                   active ? timer + 32'd1 : timer;
        flag_d   = match || (flag && !(wr_tstat && wdata[TSTAT_MATCH]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= TIMER_RST;
            tcmp  <= TCMP_RST;
            tctrl <= TCTRL_RST;
            flag  <= 1'b0;
        end else begin
            timer <= timer_d;
            flag  <= flag_d;
            if (wr_tcmp) tcmp <= wdata;
            if (wr_tctrl) tctrl <= wdata[1:0];
        end
    end

endmodule

// File: rtl/data_mem_io.sv
// data_mem_io: byte/half/word data RAM plus a memory-mapped I/O window with
// DOUT/DIN pins and a compare timer, serving the core's data port.
module data_mem_io
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] IO_BASE     = 32'h0001_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        d_en,
    input  logic        d_rw,
    input  logic [31:0] daddr,
    input  logic [2:0]  dsize,
    input  logic [31:0] ddata_w,
    output logic [31:0] ddata_r,
    output logic        misalign,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        timer_irq
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic [4:0]    shamt;
    logic [31:0]   lane, ram_rd, io_rd, wd, timer, tcmp;
    logic [3:0]    be;
    logic [1:0]    tctrl;
    logic [15:0]   din_meta, din_sync;
    logic          flag, is_ram, is_io, ram_ok, io_ok, legal, st, ram_we, io_we;

    always_comb begin
        widx     = daddr[AW+1:2];
        shamt    = {daddr[1:0], 3'b000};
        is_ram   = {1'b0, daddr} < RAM_BYTES;
        is_io    = daddr[31:5] == IO_BASE[31:5];
        // unsigned sizes are load-only; halfwords need even, words need 4-byte alignment
        ram_ok   = dsize == SZ_B || (dsize == SZ_BU && !d_rw) ||
                   ((dsize == SZ_H || (dsize == SZ_HU && !d_rw)) && !daddr[0]) ||
                   (dsize == SZ_W && daddr[1:0] == 2'b00);
        io_ok    = dsize == SZ_W && daddr[1:0] == 2'b00 && daddr[4:0] <= OFF_TSTAT;
        legal    = is_ram ? ram_ok : is_io && io_ok;
        misalign = d_en && !legal;
        lane     = mem[widx] >> shamt;
        ram_rd   = dsize == SZ_B  ? {{24{lane[7]}}, lane[7:0]} :
                   dsize == SZ_BU ? {24'h0, lane[7:0]} :
                   dsize == SZ_H  ? {{16{lane[15]}}, lane[15:0]} :
                   dsize == SZ_HU ? {16'h0, lane[15:0]} : lane;
        io_rd    = daddr[4:0] == OFF_DOUT  ? {16'h0, DOUT} :
                   daddr[4:0] == OFF_DIN   ? {16'h0, din_sync} :
                   daddr[4:0] == OFF_TIMER ? timer :
                   daddr[4:0] == OFF_TCMP  ? tcmp :
                   daddr[4:0] == OFF_TCTRL ? {30'h0, tctrl} : {31'h0, flag};
        ddata_r  = !(d_en && legal) ? 32'h0 : is_ram ? ram_rd : io_rd;
        st       = d_en && d_rw && legal;
        ram_we   = st && is_ram && !RESET;
        io_we    = st && !is_ram;
        be       = (dsize[1:0] == 2'b00 ? 4'b0001 : dsize[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << daddr[1:0];
        wd       = ddata_w << shamt;
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < 4; b++)
            if (ram_we && be[b]) mem[widx][b*8 +: 8] <= wd[b*8 +: 8];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DOUT     <= DOUT_RST;
            din_meta <= 16'h0;
            din_sync <= 16'h0;
        end else begin
            din_meta <= DIN;
            din_sync <= din_meta;
            if (io_we && daddr[4:0] == OFF_DOUT) DOUT <= ddata_w[15:0];
        end
    end

    io_timer u_timer (
        .clk   (CLK),
        .rst   (RESET),
        .we    (io_we),
        .off   (daddr[4:0]),
        .wdata (ddata_w),
        .timer (timer),
        .tcmp  (tcmp),
        .tctrl (tctrl),
        .flag  (flag)
    );

    assign timer_irq = flag;

endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: scoreboard bench for data_mem_io with a byte-array RAM model
// and directed I/O, timer and reset scenarios.
module tb_data_mem_io;

    localparam logic [31:0] IOB = 32'h0001_0000;

    logic        CLK = 0, RESET = 0, d_en = 0, d_rw = 0, misalign, timer_irq;
    logic [31:0] daddr = 0, ddata_w = 0, ddata_r;
    logic [2:0]  dsize = 0;
    logic [15:0] DIN = 0, DOUT;

    int n_chk = 0, n_fail = 0;
    logic [7:0] mref [0:4095];

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic        cd;
        string       tag;
    } exp_t;
    exp_t sb[$];
    exp_t e_mon;

    data_mem_io #(.DEPTH_WORDS(1024), .IO_BASE(IOB)) dut (
        .CLK(CLK), .RESET(RESET), .d_en(d_en), .d_rw(d_rw), .daddr(daddr),
        .dsize(dsize), .ddata_w(ddata_w), .ddata_r(ddata_r), .misalign(misalign),
        .DIN(DIN), .DOUT(DOUT), .timer_irq(timer_irq)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference: bytes little-endian, sign-extend signed B/H, legality from size and alignment.
    function automatic void model(input logic rw, input logic [31:0] a, input logic [2:0] sz,
                                  output logic [31:0] d, output logic ok, output int n);
        n = (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : (sz == 3'd2) ? 4 : 0;
        ok = a < 32'd4096 && n != 0 && (a % n) == 0 && !(rw && sz[2]);
        d = 0;
        if (ok && !rw) begin
            for (int i = n - 1; i >= 0; i--) d = (d << 8) | 32'(mref[a + i]);
            if (!sz[2] && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8 * n)) - 32'd1);
        end
    endfunction

    task automatic bus(input logic rw, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                       input logic m, input logic cd, input logic [31:0] ed, input string tag);
        exp_t e;
        e.d = ed; e.m = m; e.cd = cd && !rw; e.tag = tag;
        sb.push_back(e);
        d_en = 1; d_rw = rw; daddr = a; dsize = sz; ddata_w = wd;
        @(posedge CLK); #1;
        d_en = 0;
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] ed, input string tag);
        bus(1'b0, a, 3'd2, 32'h0, 1'b0, 1'b1, ed, tag);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] wd, input string tag);
        bus(1'b1, a, 3'd2, wd, 1'b0, 1'b0, 32'h0, tag);
    endtask

    task automatic do_op(input logic rw, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        logic ok;
        int n;
        model(rw, a, sz, d, ok, n);
        bus(rw, a, sz, wd, !ok, 1'b1, d, $sformatf("%s a=%h sz=%0d", rw ? "store" : "load", a, sz));
        if (ok && rw) for (int i = 0; i < n; i++) mref[a + i] = wd[8*i +: 8];
    endtask

    always @(negedge CLK) begin
        if (d_en) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard empty: access at %h got data %h, expected no access", daddr, ddata_r);
            end else begin
                e_mon = sb.pop_front();
                chk({e_mon.tag, " misalign"}, {31'h0, misalign}, {31'h0, e_mon.m});
                if (e_mon.cd) chk({e_mon.tag, " data"}, ddata_r, e_mon.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks done", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        #1 RESET = 1;
        #2;
        chk("reset DOUT", {16'h0, DOUT}, 32'h0);
        chk("reset irq", {31'h0, timer_irq}, 32'h0);
        @(posedge CLK); #1;
        RESET = 0;
        lw(IOB + 8, 32'h0, "TIMER reset");
        lw(IOB + 12, 32'hFFFF_FFFF, "TCMP reset");
        lw(IOB + 16, 32'h0, "TCTRL reset");
        lw(IOB + 20, 32'h0, "TSTAT reset");

        do_op(1'b1, 32'h10, 3'd2, 32'h8081_8283);
        bus(1'b0, 32'h11, 3'd0, 0, 1'b0, 1'b1, 32'hFFFF_FF82, "LB 0x11");
        bus(1'b0, 32'h11, 3'd4, 0, 1'b0, 1'b1, 32'h0000_0082, "LBU 0x11");
        bus(1'b0, 32'h12, 3'd1, 0, 1'b0, 1'b1, 32'hFFFF_8081, "LH 0x12");
        bus(1'b0, 32'h12, 3'd5, 0, 1'b0, 1'b1, 32'h0000_8081, "LHU 0x12");
        do_op(1'b1, 32'h13, 3'd0, 32'h0000_005A);
        lw(32'h10, 32'h5A81_8283, "LW after SB");
        bus(1'b0, 32'h12, 3'd2, 0, 1'b1, 1'b1, 32'h0, "LW 0x12 misaligned");
        do_op(1'b1, 32'h11, 3'd1, 32'h0000_FFFF);
        do_op(1'b1, 32'h10, 3'd4, 32'h0000_0000);
        lw(32'h10, 32'h5A81_8283, "RAM unchanged after illegal stores");
        bus(1'b0, IOB, 3'd0, 0, 1'b1, 1'b1, 32'h0, "LB IO_BASE");
        bus(1'b0, 32'h0002_0000, 3'd2, 0, 1'b1, 1'b1, 32'h0, "unmapped load");

        daddr = 32'h12; dsize = 3'd2; d_rw = 0;
        #2;
        chk("idle ddata_r", ddata_r, 32'h0);
        chk("idle misalign", {31'h0, misalign}, 32'h0);
        @(posedge CLK); #1;

        chk("DOUT before write", {16'h0, DOUT}, 32'h0);
        sw(IOB, 32'hABCD_1234, "SW DOUT");
        chk("DOUT on write edge", {16'h0, DOUT}, 32'h0000_1234);

        DIN = 16'hBEEF;
        lw(IOB + 4, 32'h0, "DIN before any edge");
        lw(IOB + 4, 32'h0, "DIN after one edge");
        lw(IOB + 4, 32'h0000_BEEF, "DIN after two edges");

        sw(IOB + 12, 32'd5, "TCMP=5");
        sw(IOB + 16, 32'd3, "TCTRL=3");
        for (int i = 1; i <= 5; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("irq low at edge %0d", i), {31'h0, timer_irq}, 32'h0);
        end
        @(posedge CLK); #1;
        chk("irq high at edge 6", {31'h0, timer_irq}, 32'h1);
        lw(IOB + 8, 32'h0, "TIMER auto-reloaded");
        lw(IOB + 20, 32'h1, "TSTAT match flag");
        sw(IOB + 16, 32'd0, "disable timer");
        sw(IOB + 20, 32'd1, "W1C TSTAT");
        chk("irq cleared by W1C", {31'h0, timer_irq}, 32'h0);

        sw(IOB + 8, 32'd0, "TIMER=0");
        sw(IOB + 12, 32'd3, "TCMP=3");
        sw(IOB + 16, 32'd1, "enable no reload");
        repeat (3) @(posedge CLK);
        #1;
        chk("irq low before match", {31'h0, timer_irq}, 32'h0);
        sw(IOB + 20, 32'd1, "W1C during match");
        chk("match beats W1C", {31'h0, timer_irq}, 32'h1);
        sw(IOB + 20, 32'd1, "W1C after match");
        chk("W1C clears flag", {31'h0, timer_irq}, 32'h0);

        sw(IOB + 8, 32'd100, "TIMER=100 while enabled");
        lw(IOB + 8, 32'd100, "TIMER write beats increment");
        lw(IOB + 8, 32'd101, "TIMER keeps counting");
        sw(IOB + 12, 32'd110, "TCMP=110");
        for (int i = 0; i < 40 && timer_irq !== 1'b1; i++) begin
            @(posedge CLK); #1;
        end
        chk("irq before reset", {31'h0, timer_irq}, 32'h1);
        chk("DOUT before reset", {16'h0, DOUT}, 32'h0000_1234);

        #1 RESET = 1;
        #1;
        chk("DOUT async reset", {16'h0, DOUT}, 32'h0);
        chk("irq async reset", {31'h0, timer_irq}, 32'h0);
        d_en = 1; d_rw = 0; daddr = IOB + 8; dsize = 3'd2;
        #1;
        chk("TIMER async reset", ddata_r, 32'h0);
        d_en = 0;
        @(posedge CLK); #1;
        bus(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, "store during reset");
        RESET = 0;
        lw(32'h10, 32'h5A81_8283, "store in reset dropped");
        lw(IOB + 8, 32'h0, "TIMER after reset");
        lw(IOB + 8, 32'h0, "TIMER stays disabled");
        lw(IOB + 16, 32'h0, "TCTRL after reset");

        for (int w = 0; w < 16; w++) do_op(1'b1, 32'h100 + 32'(4 * w), 3'd2, $urandom);
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'h2000_0000 | 32'($urandom_range(0, 255)))
                                            : 32'h100 + 32'($urandom_range(0, 63));
            do_op(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge CLK); #1;
            end
        end

        @(posedge CLK); #1;
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
